// File: rtl/br_tag_manager_pkg.sv
// Shared branch-tag types: tag count, one-hot mask type, resolution task encoding and small mask helpers.
package br_tag_manager_pkg;

  localparam int NUM_BRANCHES = 4;
  localparam int N_BR         = NUM_BRANCHES;
  localparam int CNT_W        = $clog2(N_BR + 1);

  typedef logic [N_BR-1:0] br_mask_t;

  typedef enum logic [1:0] {
    NOTHING = 2'd0,
    CLEAR   = 2'd1,
    SQUASH  = 2'd2
  } br_task_t;

  function automatic logic is_onehot(input br_mask_t m);
    return (m != '0) && ((m & (m - br_mask_t'(1))) == '0);
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input br_mask_t m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_BR; i++) begin
      c = c + CNT_W'(m[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/br_psel.sv
// Lowest-index one-hot picker: gnt has only the least significant set bit of req, zero when req is zero.
module br_psel #(
  parameter int W = 4
) (
  input  logic [W-1:0] req,
  output logic [W-1:0] gnt
);

  assign gnt = req & (~req + W'(1));

endmodule

// File: rtl/br_tag_manager.sv
// Branch-tag pool: grants one-hot b_ids to dispatch, tracks older-branch dependencies per tag, and
// rebroadcasts accepted CLEAR/SQUASH resolutions one cycle later.
module br_tag_manager
  import br_tag_manager_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output br_mask_t         alloc_b_id,
  output br_mask_t         cur_b_mask,
  input  logic             res_valid,
  input  br_task_t         res_task,
  input  br_mask_t         res_b_id,
  output br_task_t         rem_br_task,
  output br_mask_t         rem_b_id,
  output logic             full,
  output logic [CNT_W-1:0] free_cnt,
  output logic             err
);

  br_mask_t free;
  br_mask_t dep [N_BR];
  br_mask_t pick;
  br_mask_t kill;
  br_mask_t dep_x;
  br_mask_t clr_bit;
  br_mask_t free_n;
  br_mask_t cur_n;
  logic     squash_in;
  logic     res_ok;
  logic     res_err;
  logic     clear_ok;
  logic     squash_ok;

  br_psel #(.W(N_BR)) u_psel (
    .req (free),
    .gnt (pick)
  );

  // Any squash on the bus blocks allocation, even one later rejected, so the grant never waits on the tag check.
  assign squash_in  = res_valid && (res_task == SQUASH);
  assign alloc_gnt  = alloc_req && (|free) && !squash_in;
  assign alloc_b_id = alloc_gnt ? pick : '0;

  // Undefined task encodings are rejected like any other malformed resolution.
  assign res_ok    = res_valid && (res_task inside {CLEAR, SQUASH}) &&
                     is_onehot(res_b_id) && (|(res_b_id & ~free));
  assign res_err   = res_valid && (res_task != NOTHING) && !res_ok;
  assign clear_ok  = res_ok && (res_task == CLEAR);
  assign squash_ok = res_ok && (res_task == SQUASH);
  assign clr_bit   = clear_ok ? res_b_id : '0;

  always_comb begin
    kill  = '0;
    dep_x = '0;
    for (int t = 0; t < N_BR; t++) begin
      kill[t] = res_b_id[t] | (|(dep[t] & res_b_id));
      if (res_b_id[t]) begin
        dep_x = dep_x | dep[t];
      end
    end
  end

  // A granted tag comes from the registered free vector, so it never collides with a tag freed this cycle.
  always_comb begin
    free_n = (free | clr_bit | (squash_ok ? kill : '0)) & ~alloc_b_id;
    cur_n  = squash_ok ? dep_x : ((cur_b_mask & ~clr_bit) | alloc_b_id);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      free        <= '1;
      cur_b_mask  <= '0;
      rem_br_task <= NOTHING;
      rem_b_id    <= '0;
      full        <= 1'b0;
      free_cnt    <= CNT_W'(N_BR);
      err         <= 1'b0;
      for (int t = 0; t < N_BR; t++) begin
        dep[t] <= '0;
      end
    end else begin
      free        <= free_n;
      cur_b_mask  <= cur_n;
      rem_br_task <= res_ok ? res_task : NOTHING;
      rem_b_id    <= res_ok ? res_b_id : '0;
      full        <= (free_n == '0);
      free_cnt    <= popcount(free_n);
      if (res_err) begin
        err <= 1'b1;
      end
      for (int t = 0; t < N_BR; t++) begin
        if (squash_ok && kill[t]) begin
          dep[t] <= '0;
        end else if (alloc_b_id[t]) begin
          dep[t] <= cur_b_mask & ~clr_bit;
        end else begin
          dep[t] <= dep[t] & ~clr_bit;
        end
      end
    end
  end

endmodule

// File: tb/tb_br_tag_manager.sv
// Directed bench for br_tag_manager: fill, clear, squash, reuse, clear-with-alloc and bad resolutions.
module tb_br_tag_manager;
  import br_tag_manager_pkg::*;

  logic             clock;
  logic             reset;
  logic             alloc_req;
  logic             alloc_gnt;
  br_mask_t         alloc_b_id;
  br_mask_t         cur_b_mask;
  logic             res_valid;
  br_task_t         res_task;
  br_mask_t         res_b_id;
  br_task_t         rem_br_task;
  br_mask_t         rem_b_id;
  logic             full;
  logic [CNT_W-1:0] free_cnt;
  logic             err;

  int checks = 0;
  int errors = 0;

  br_tag_manager dut (
    .clock       (clock),
    .reset       (reset),
    .alloc_req   (alloc_req),
    .alloc_gnt   (alloc_gnt),
    .alloc_b_id  (alloc_b_id),
    .cur_b_mask  (cur_b_mask),
    .res_valid   (res_valid),
    .res_task    (res_task),
    .res_b_id    (res_b_id),
    .rem_br_task (rem_br_task),
    .rem_b_id    (rem_b_id),
    .full        (full),
    .free_cnt    (free_cnt),
    .err         (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic resolve(input br_task_t tk, input br_mask_t id);
    res_valid = 1'b1;
    res_task  = tk;
    res_b_id  = id;
  endtask

  task automatic idle_res();
    res_valid = 1'b0;
    res_task  = NOTHING;
    res_b_id  = '0;
  endtask

  task automatic check_state(input string tag, input br_mask_t mask, input int cnt, input logic fl);
    check({tag, "_mask"}, 32'(cur_b_mask), 32'(mask));
    check({tag, "_cnt"},  32'(free_cnt),   32'(cnt));
    check({tag, "_full"}, 32'(full),       32'(fl));
  endtask

  task automatic check_rem(input string tag, input br_task_t tk, input br_mask_t id);
    check({tag, "_task"}, 32'(rem_br_task), 32'(tk));
    check({tag, "_id"},   32'(rem_b_id),    32'(id));
  endtask

  task automatic fill(input int n);
    alloc_req = 1'b1;
    repeat (n) step();
    alloc_req = 1'b0;
  endtask

  br_mask_t fill_id  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
  logic     fill_gnt [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    reset     = 1'b0;
    alloc_req = 1'b0;
    idle_res();
    repeat (2) step();
    check_state("rst", 4'b0000, 4, 1'b0);
    check_rem("rst", NOTHING, 4'b0000);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b1;
    step();

    // Fill: four grants lowest-first, fifth request refused.
    for (int i = 0; i < 5; i++) begin
      alloc_req = 1'b1;
      #1;
      check($sformatf("fill%0d_gnt", i), 32'(alloc_gnt),  32'(fill_gnt[i]));
      check($sformatf("fill%0d_id", i),  32'(alloc_b_id), 32'(fill_id[i]));
      step();
    end
    alloc_req = 1'b0;
    check_state("fill", 4'b1111, 0, 1'b1);

    // Clear tag1, then squash tag0 kills tags 2 and 3.
    resolve(CLEAR, 4'b0010);
    step();
    idle_res();
    check_rem("clr", CLEAR, 4'b0010);
    check_state("clr", 4'b1101, 1, 1'b0);
    step();
    check_rem("clr_idle", NOTHING, 4'b0000);
    resolve(SQUASH, 4'b0001);
    step();
    idle_res();
    check_rem("sq0", SQUASH, 4'b0001);
    check_state("sq0", 4'b0000, 4, 1'b0);

    // Squash tag1 with a concurrent request: no grant, mask falls back to dep of tag1.
    fill(4);
    check_state("fill2", 4'b1111, 0, 1'b1);
    alloc_req = 1'b1;
    resolve(SQUASH, 4'b0010);
    #1;
    check("sq1_gnt", 32'(alloc_gnt),  32'd0);
    check("sq1_id",  32'(alloc_b_id), 32'd0);
    step();
    alloc_req = 1'b0;
    idle_res();
    check_rem("sq1", SQUASH, 4'b0010);
    check_state("sq1", 4'b0001, 3, 1'b0);

    // Reuse: freed tag2 grantable only on the following cycle.
    fill(3);
    check_state("fill3", 4'b1111, 0, 1'b1);
    alloc_req = 1'b1;
    resolve(CLEAR, 4'b0100);
    #1;
    check("reuse_gnt0", 32'(alloc_gnt), 32'd0);
    step();
    idle_res();
    #1;
    check("reuse_gnt1", 32'(alloc_gnt),  32'd1);
    check("reuse_id1",  32'(alloc_b_id), 32'(4'b0100));
    check_rem("reuse", CLEAR, 4'b0100);
    step();
    alloc_req = 1'b0;
    check_state("reuse", 4'b1111, 0, 1'b1);

    // Clear tag0 while granting tag3: tag3 dep must not keep bit0.
    resolve(CLEAR, 4'b1000);
    step();
    resolve(CLEAR, 4'b0001);
    alloc_req = 1'b1;
    #1;
    check("ca_gnt", 32'(alloc_gnt),  32'd1);
    check("ca_id",  32'(alloc_b_id), 32'(4'b1000));
    step();
    idle_res();
    check_state("ca", 4'b1110, 1, 1'b0);
    step();
    alloc_req = 1'b0;
    check_state("ca_re", 4'b1111, 0, 1'b1);
    resolve(SQUASH, 4'b0001);
    step();
    idle_res();
    check_rem("ca_sq", SQUASH, 4'b0001);
    check_state("ca_sq", 4'b1110, 1, 1'b0);

    // Bad resolutions: free tag, then non-one-hot tag.
    check("bad_err0", 32'(err), 32'd0);
    resolve(CLEAR, 4'b0001);
    step();
    idle_res();
    check_rem("bad_clr", NOTHING, 4'b0000);
    check_state("bad_clr", 4'b1110, 1, 1'b0);
    check("bad_clr_err", 32'(err), 32'd1);
    resolve(SQUASH, 4'b0011);
    step();
    idle_res();
    check_rem("bad_sq", NOTHING, 4'b0000);
    check_state("bad_sq", 4'b1110, 1, 1'b0);
    check("bad_sq_err", 32'(err), 32'd1);

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #2;
    reset = 1'b0;
    #1;
    check_state("arst", 4'b0000, 4, 1'b0);
    check_rem("arst", NOTHING, 4'b0000);
    check("arst_err", 32'(err), 32'd0);
    reset = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
